// File: rtl/sdram_cmd_pkg.sv
// Shared encodings for the SDRAM command interface; the frame-buffer arbiter
// imports the same package so both sides agree on command values.
package sdram_cmd_pkg;

  localparam int SDRAM_ADDR_WIDTH = 22;
  localparam int SDRAM_DATA_WIDTH = 16;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE_CAPTURE,
    ST_WRITE_WAIT,
    ST_READ_LATENCY,
    ST_READ_BURST,
    ST_DONE,
    ST_REFRESH
  } resp_state_e;

endpackage

// File: rtl/cmd_responder_ram.sv
// Simple dual-port backing store: one write port, one registered read port.
module cmd_responder_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // No reset on the array or read register so the tools map this to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdram_cmd_responder.sv
// Block-RAM stand-in for the SDRAM controller: wrapped write/read bursts,
// controller-like read latency and refresh stalls taken only between bursts.
module sdram_cmd_responder
  import sdram_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH         = 12,
  parameter int READ_BURST_LENGTH  = 8,
  parameter int WRITE_BURST_LENGTH = 8,
  parameter int READ_LATENCY       = 3,
  parameter int REFRESH_INTERVAL   = 780,
  parameter int REFRESH_CYCLES     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  command,
  input  logic [SDRAM_ADDR_WIDTH-1:0] data_address,
  input  logic [SDRAM_DATA_WIDTH-1:0] data_write,
  output logic [SDRAM_DATA_WIDTH-1:0] data_read,
  output logic                        data_read_valid,
  output logic                        data_write_done
);

  localparam int RCW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [3:0]            beat,
    input int                    bl
  );
    logic [ADDR_WIDTH-1:0] m;
    m = ADDR_WIDTH'(bl - 1);
    return (b & ~m) | ((b + ADDR_WIDTH'(beat)) & m);
  endfunction

  resp_state_e           state, state_n;
  logic [ADDR_WIDTH-1:0] base_q, base_n, addr_lo;
  logic [3:0]            beat, beat_n;
  logic [15:0]           wait_cnt, wait_n;
  logic                  rd_pend, done_n, rfr_take, rfr_tick, rfr_pending;
  logic [RCW-1:0]        rfr_cnt;

  logic                        ram_we, ram_re;
  logic [ADDR_WIDTH-1:0]       ram_waddr, ram_raddr;
  logic [SDRAM_DATA_WIDTH-1:0] ram_rdata;

  assign addr_lo  = data_address[ADDR_WIDTH-1:0];
  assign rfr_tick = (REFRESH_INTERVAL != 0) && (rfr_cnt == RCW'(REFRESH_INTERVAL - 1));

  generate
    if (ADDR_WIDTH < SDRAM_ADDR_WIDTH) begin : g_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^data_address[SDRAM_ADDR_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  cmd_responder_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(SDRAM_DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (data_write),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    base_n    = base_q;
    beat_n    = beat;
    wait_n    = wait_cnt;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = wrap_addr(base_q, beat, WRITE_BURST_LENGTH);
    ram_raddr = wrap_addr(base_q, beat, READ_BURST_LENGTH);
    done_n    = 1'b0;
    rfr_take  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rfr_pending) begin
          state_n  = ST_REFRESH;
          wait_n   = 16'(REFRESH_CYCLES - 1);
          rfr_take = 1'b1;
        end else if (command == CMD_WRITE) begin
          // Beat 0 lands on the accept edge itself.
          base_n    = addr_lo;
          beat_n    = 4'd1;
          ram_we    = 1'b1;
          ram_waddr = addr_lo;
          done_n    = 1'b1;
          state_n   = ST_WRITE_WAIT;
        end else if (command == CMD_READ) begin
          base_n  = addr_lo;
          beat_n  = 4'd0;
          wait_n  = 16'(READ_LATENCY - 2);
          state_n = ST_READ_LATENCY;
        end
      end
      ST_WRITE_WAIT:
        state_n = (beat == 4'(WRITE_BURST_LENGTH)) ? ST_DONE : ST_WRITE_CAPTURE;
      ST_WRITE_CAPTURE: begin
        ram_we  = 1'b1;
        done_n  = 1'b1;
        beat_n  = beat + 4'd1;
        state_n = ST_WRITE_WAIT;
      end
      ST_READ_LATENCY: begin
        // Issue beat 0 one edge early to cover the registered RAM read.
        if (wait_cnt == 16'd0) begin
          ram_re  = 1'b1;
          beat_n  = beat + 4'd1;
          state_n = ST_READ_BURST;
        end else begin
          wait_n = wait_cnt - 16'd1;
        end
      end
      ST_READ_BURST: begin
        if (beat != 4'(READ_BURST_LENGTH)) begin
          ram_re = 1'b1;
          beat_n = beat + 4'd1;
        end else if (!rd_pend) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      ST_REFRESH: begin
        if (wait_cnt == 16'd0) state_n = ST_IDLE;
        else                   wait_n  = wait_cnt - 16'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q          <= '0;
      beat            <= '0;
      wait_cnt        <= '0;
      rd_pend         <= 1'b0;
      data_read       <= '0;
      data_read_valid <= 1'b0;
      data_write_done <= 1'b0;
      rfr_cnt         <= '0;
      rfr_pending     <= 1'b0;
    end else begin
      base_q          <= base_n;
      beat            <= beat_n;
      wait_cnt        <= wait_n;
      rd_pend         <= ram_re;
      data_read_valid <= rd_pend;
      data_write_done <= done_n;
      if (rd_pend) data_read <= ram_rdata;
      rfr_cnt <= (REFRESH_INTERVAL == 0 || rfr_tick) ? '0 : rfr_cnt + 1'b1;
      // A new tick wins over the clear, so back-to-back requests are never lost.
      if (rfr_tick)      rfr_pending <= 1'b1;
      else if (rfr_take) rfr_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench: table-driven write/read bursts plus hand-timed held-command,
// reset and refresh sequences against two responder instances.
module tb_sdram_cmd_responder;
  import sdram_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  command;
  logic [21:0] data_address;
  logic [15:0] data_write;
  logic [15:0] rd_a, rd_r_unused;
  logic        vld_a, vld_r, done_a, done_r;

  always #5 clk = ~clk;

  sdram_cmd_responder #(.REFRESH_INTERVAL(0)) dut (
    .clk(clk), .reset_n(reset_n), .command(command), .data_address(data_address),
    .data_write(data_write), .data_read(rd_a), .data_read_valid(vld_a),
    .data_write_done(done_a)
  );

  sdram_cmd_responder #(.REFRESH_INTERVAL(64), .REFRESH_CYCLES(4)) dut_rfr (
    .clk(clk), .reset_n(reset_n), .command(command), .data_address(data_address),
    .data_write(data_write), .data_read(rd_r_unused), .data_read_valid(vld_r),
    .data_write_done(done_r)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [21:0] addr;
    logic [15:0] wd;
    logic        e_done;
    logic        e_vld;
    logic        chk_rd;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl [0:31];
  int   tbl_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Write burst at vector 0, read accepted at vector 17, beats after vectors 20..27.
  task automatic fill_wr_rd(input logic [21:0] wbase, input logic [15:0] d0,
                            input logic [21:0] rbase);
    tbl_n = 30;
    for (int i = 0; i < 32; i++) begin
      tbl[i].cmd = 2'd0; tbl[i].addr = '0; tbl[i].wd = '0;
      tbl[i].e_done = 1'b0; tbl[i].e_vld = 1'b0; tbl[i].chk_rd = 1'b0; tbl[i].e_rd = '0;
    end
    tbl[0].cmd  = CMD_WRITE;
    tbl[0].addr = wbase;
    for (int k = 0; k < 8; k++) begin
      tbl[2*k].wd       = d0 + 16'(k);
      tbl[2*k].e_done   = 1'b1;
      tbl[2*k+1].wd     = d0 + 16'(k + 1);
    end
    tbl[17].cmd  = CMD_READ;
    tbl[17].addr = rbase;
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (int'(rbase[2:0]) + k - int'(wbase[2:0]) + 8) % 8;
      tbl[20+k].e_vld  = 1'b1;
      tbl[20+k].chk_rd = 1'b1;
      tbl[20+k].e_rd   = d0 + 16'(j);
    end
    for (int i = 28; i < 30; i++) begin
      tbl[i].chk_rd = 1'b1;
      tbl[i].e_rd   = tbl[27].e_rd;
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl_n; i++) begin
      command      = tbl[i].cmd;
      data_address = tbl[i].addr;
      data_write   = tbl[i].wd;
      step();
      chk($sformatf("%s done[%0d]", name, i), done_a, tbl[i].e_done);
      chk($sformatf("%s valid[%0d]", name, i), vld_a, tbl[i].e_vld);
      if (tbl[i].chk_rd) chk($sformatf("%s rdata[%0d]", name, i), rd_a, tbl[i].e_rd);
    end
  endtask

  initial begin
    reset_n = 1'b0; command = CMD_READ; data_address = '0; data_write = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset rdata", rd_a, 0);
      chk("reset valid", vld_a, 0);
      chk("reset done", done_a, 0);
    end
    command = CMD_IDLE;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post-reset valid", vld_a, 0);
      chk("post-reset done", done_a, 0);
    end

    fill_wr_rd(22'h000010, 16'hA000, 22'h000010);
    run_table("wr_rd");
    fill_wr_rd(22'h000006, 16'hB000, 22'h000000);
    run_table("wrap");
    step(); step();

    // Read held through its end: DONE ignores it, re-accept one cycle later.
    command = CMD_READ; data_address = 22'h000010;
    for (int t = 0; t < 26; t++) begin
      logic ev;
      step();
      if (t == 13) command = CMD_IDLE;
      ev = (t >= 3 && t <= 10) || (t >= 16 && t <= 23);
      chk($sformatf("held valid[%0d]", t), vld_a, ev);
      if (t >= 3 && t <= 10)  chk($sformatf("held rdata[%0d]", t), rd_a, 16'hA000 + 16'(t - 3));
      if (t >= 16 && t <= 23) chk($sformatf("held rdata[%0d]", t), rd_a, 16'hA000 + 16'(t - 16));
    end

    command = 2'd3;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("reserved valid", vld_a, 0);
      chk("reserved done", done_a, 0);
    end
    command = CMD_IDLE;
    step();

    // Reset after beat 3 of a read, then confirm RAM survived.
    command = CMD_READ; data_address = 22'h000010;
    step();
    command = CMD_IDLE;
    for (int t = 1; t <= 6; t++) step();
    chk("mid beat3 valid", vld_a, 1);
    chk("mid beat3 rdata", rd_a, 16'hA003);
    reset_n = 1'b0;
    step();
    chk("mid reset valid", vld_a, 0);
    chk("mid reset rdata", rd_a, 0);
    step();
    reset_n = 1'b1;
    step(); step();
    command = CMD_READ; data_address = 22'h000000;
    step();
    command = CMD_IDLE;
    for (int t = 1; t <= 12; t++) begin
      step();
      chk($sformatf("after reset valid[%0d]", t), vld_a, (t >= 3 && t <= 10));
      if (t >= 3 && t <= 10)
        chk($sformatf("after reset rdata[%0d]", t), rd_a, 16'hB000 + 16'((t - 3 + 2) % 8));
    end

    // Refresh instance: first request pends at edge 64 after release, second at 128.
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    cyc = 0;
    while (cyc < 156) begin
      int nx;
      logic ev;
      nx = cyc + 1;
      command = ((nx >= 66 && nx <= 70) || nx == 124 || (nx >= 136 && nx <= 142))
                ? CMD_READ : CMD_IDLE;
      data_address = '0;
      step();
      ev = (cyc >= 73 && cyc <= 80) || (cyc >= 127 && cyc <= 134) || (cyc >= 145 && cyc <= 152);
      chk($sformatf("refresh valid[%0d]", cyc), vld_r, ev);
      if (cyc == 100) chk("refresh done", done_r, 0);
    end
    command = CMD_IDLE;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
